// File: rtl/rx_lane_arb.sv
// rx_lane_arb: round-robin merge of per-lane 8b/10b decoder bytes into a single downstream queue,
// dropping error bytes (counted) and idle K28.5 fillers.
module rx_lane_arb #(
   parameter int NLANES = 4,
   parameter int NBITS  = 8,
   parameter int DEPTH  = 8
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic [NLANES-1:0]            lane_valid,
   input  logic [NLANES-1:0][NBITS-1:0] lane_data,
   input  logic [NLANES-1:0]            lane_kchar,
   input  logic [NLANES-1:0]            lane_err,
   output logic [NLANES-1:0]            lane_ready,
   input  logic                         deq_req,
   input  logic                         flush,
   output logic                         que_en,
   output logic [NBITS-1:0]             que_in,
   output logic                         que_dec,
   output logic                         que_clear,
   output logic [3:0]                   count_in,
   output logic [7:0]                   err_count
);
   localparam int            PW      = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam logic [PW-1:0] LAST    = PW'(NLANES - 1);
   localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
   localparam logic [NBITS-1:0] K285 = NBITS'(8'hBC);

   logic [NLANES-1:0]            hold_vld_q, hold_vld_d;
   logic [NLANES-1:0][NBITS-1:0] hold_data_q, hold_data_d;
   logic [PW-1:0]                rr_q, rr_d;
   logic [3:0]                   occ_q, occ_d;
   logic                         que_en_q, que_en_d;
   logic [NBITS-1:0]             que_in_q, que_in_d;
   logic                         que_clear_q, que_clear_d;
   logic [7:0]                   err_q, err_d;

   logic                         space;
   logic                         any_grant;
   logic [PW-1:0]                gidx;
   logic [PW-1:0]                idx;
   logic [NLANES-1:0]            grant;
   logic [NLANES-1:0]            take;
   logic [NLANES-1:0]            keep;
   logic [8:0]                   err_sum;

   // A full queue still accepts a byte when a pop frees a slot in the same cycle.
   assign que_dec = deq_req && (occ_q != 4'd0) && !flush;
   assign space   = (occ_q < DEPTH_C) || ((occ_q == DEPTH_C) && que_dec);

   always_comb begin
      grant     = '0;
      gidx      = rr_q;
      idx       = '0;
      any_grant = 1'b0;
      for (int k = 1; k <= NLANES; k++) begin
         idx = PW'((int'(rr_q) + k) % NLANES);
         if (!any_grant && !flush && space && hold_vld_q[idx]) begin
            any_grant = 1'b1;
            gidx      = idx;
         end
      end
      if (any_grant) grant[gidx] = 1'b1;
   end

   assign lane_ready = !nRST ? '1 : (flush ? '0 : (~hold_vld_q | grant));
   assign take       = lane_valid & lane_ready;

   always_comb begin
      keep        = '0;
      hold_data_d = hold_data_q;
      err_sum     = {1'b0, err_q};
      for (int i = 0; i < NLANES; i++) begin
         keep[i] = take[i] && !lane_err[i] && !(lane_kchar[i] && (lane_data[i] == K285));
         if (keep[i]) hold_data_d[i] = lane_data[i];
         err_sum = err_sum + 9'(take[i] & lane_err[i]);
      end
      hold_vld_d  = flush ? '0 : ((hold_vld_q & ~grant) | keep);
      err_d       = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
      occ_d       = flush ? 4'd0 : (occ_q + 4'(any_grant) - 4'(que_dec));
      rr_d        = flush ? LAST : (any_grant ? gidx : rr_q);
      que_en_d    = any_grant;
      que_in_d    = any_grant ? hold_data_q[gidx] : que_in_q;
      que_clear_d = flush;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hold_vld_q  <= '0;
         hold_data_q <= '0;
         rr_q        <= LAST;
         occ_q       <= 4'd0;
         que_en_q    <= 1'b0;
         que_in_q    <= '0;
         que_clear_q <= 1'b0;
         err_q       <= 8'd0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         rr_q        <= rr_d;
         occ_q       <= occ_d;
         que_en_q    <= que_en_d;
         que_in_q    <= que_in_d;
         que_clear_q <= que_clear_d;
         err_q       <= err_d;
      end
   end

   assign que_en    = que_en_q;
   assign que_in    = que_in_q;
   assign que_clear = que_clear_q;
   assign count_in  = occ_q;
   assign err_count = err_q;
endmodule
